// File: rtl/booth_pkg.sv
// Shared definitions for the Booth product accumulator slice.
// Contents:
//   PROD_W_DEF / ACC_W_DEF         default product and accumulator widths
//   state_t                        burst FSM state (IDLE, ACCUM, HOLD)
//   ACC_SAT_MAX_DEF / _MIN_DEF     saturation limits for the default ACC_W
package booth_pkg;

    localparam int PROD_W_DEF = 10;
    localparam int ACC_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [ACC_W_DEF-1:0] ACC_SAT_MAX_DEF = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic [ACC_W_DEF-1:0] ACC_SAT_MIN_DEF = {1'b1, {(ACC_W_DEF-1){1'b0}}};

endpackage

// File: rtl/booth_pend_fifo.sv
// Small synchronous FIFO holding products that arrive while a result is held.
// Ports:
//   clock, rst   rising-edge clock, asynchronous active-high reset
//   flush        synchronous empty
//   push, din    write request and data (ignored when full unless popping)
//   pop          remove head (ignored when empty)
//   head         oldest entry
//   full, empty  occupancy flags
// DEPTH must be a power of two, 2 minimum.
module booth_pend_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             wr_en, rd_en;

    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign head  = mem_q[rd_q];

    // A push into a full FIFO is accepted when the head leaves the same cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + AW'(1);
            if (rd_en) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en && !flush) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/booth_product_accumulator.sv
// Accumulates bursts of BURST_LEN signed products into an ACC_W-bit sum and
// presents each finished sum on a valid/ready port. Products arriving while a
// sum is held are queued in a pending FIFO; drops set the sticky overrun flag.
// Ports:
//   clock, rst            rising-edge clock, asynchronous active-high reset
//   prod_valid, prod_in   product strobe and signed product
//   clear                 synchronous soft clear (rst has priority)
//   acc_out, acc_valid    burst sum and its valid flag
//   acc_ready             consumer accepts acc_out
//   prod_count            products folded into the current burst
//   ovf, overrun          sticky overflow / pending-FIFO drop flags
// Build option: BOOTH_ACC_SATURATE_EN clamps the sum on overflow instead of
// wrapping.
module booth_product_accumulator
    import booth_pkg::*;
#(
    parameter int PROD_W     = PROD_W_DEF,
    parameter int ACC_W      = ACC_W_DEF,
    parameter int BURST_LEN  = 4,
    parameter int PEND_DEPTH = 2
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              clear,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [7:0]        prod_count,
    output logic              ovf,
    output logic              overrun
);

`ifdef BOOTH_ACC_SATURATE_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              ovr_q, ovr_d;

    logic              f_push, f_pop, f_full, f_empty;
    logic [PROD_W-1:0] f_head, src;
    logic [ACC_W-1:0]  ext, base, sum;
    logic              hs, take, add_ovf, drop;

    booth_pend_fifo #(
        .WIDTH(PROD_W),
        .DEPTH(PEND_DEPTH)
    ) u_pend (
        .clock (clock),
        .rst   (rst),
        .flush (clear),
        .push  (f_push),
        .pop   (f_pop),
        .din   (prod_in),
        .head  (f_head),
        .full  (f_full),
        .empty (f_empty)
    );

    assign hs   = (state_q == HOLD) && acc_ready;
    // In HOLD a product may only be folded in the handshake cycle.
    assign take = !clear && ((state_q != HOLD) || hs) && (!f_empty || prod_valid);
    assign src  = f_empty ? prod_in : f_head;
    assign ext  = {{(ACC_W-PROD_W){src[PROD_W-1]}}, src};
    // Outside ACCUM the first product loads rather than adds.
    assign base = (state_q == ACCUM) ? acc_q : '0;
    assign sum  = base + ext;
    assign add_ovf = (base[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);

    assign f_pop  = take && !f_empty;
    // Queue the input unless it is being bypassed straight into the adder.
    assign f_push = !clear && prod_valid && !(take && f_empty);
    assign drop   = f_push && f_full && !f_pop;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        ovr_d   = ovr_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            if (hs) begin
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
                ovr_d   = 1'b0;
            end
            if (take) begin
`ifdef BOOTH_ACC_SATURATE_EN
                acc_d = add_ovf ? (ext[ACC_W-1] ? SAT_MIN : SAT_MAX) : sum;
`else
                acc_d = sum;
`endif
                if (add_ovf) ovf_d = 1'b1;
                cnt_d   = ((state_q == ACCUM) ? cnt_q : 8'd0) + 8'd1;
                state_d = (cnt_d == 8'(BURST_LEN)) ? HOLD : ACCUM;
            end
            if (drop) ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            ovr_q   <= ovr_d;
        end
    end

    assign acc_out    = acc_q;
    assign acc_valid  = (state_q == HOLD);
    assign prod_count = cnt_q;
    assign ovf        = ovf_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_booth_product_accumulator.sv
module tb_booth_product_accumulator;

    localparam int BURST = 4;
    localparam int DEPTH = 2;
`ifdef BOOTH_ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              rst = 1'b0, prod_valid = 1'b0, clear = 1'b0, acc_ready = 1'b0;
    logic signed [9:0] prod_in = '0;

    logic signed [15:0] acc16;
    logic signed [10:0] acc11;
    logic        v16, o16, r16, v11, o11, r11;
    logic [7:0]  c16, c11;

    booth_product_accumulator #(.PROD_W(10), .ACC_W(16), .BURST_LEN(BURST), .PEND_DEPTH(DEPTH)) dut16 (
        .clock(clock), .rst(rst), .prod_valid(prod_valid), .prod_in(prod_in), .clear(clear),
        .acc_out(acc16), .acc_valid(v16), .acc_ready(acc_ready), .prod_count(c16),
        .ovf(o16), .overrun(r16));

    booth_product_accumulator #(.PROD_W(10), .ACC_W(11), .BURST_LEN(BURST), .PEND_DEPTH(DEPTH)) dut11 (
        .clock(clock), .rst(rst), .prod_valid(prod_valid), .prod_in(prod_in), .clear(clear),
        .acc_out(acc11), .acc_valid(v11), .acc_ready(acc_ready), .prod_count(c11),
        .ovf(o11), .overrun(r11));

    int cmp_n = 0;
    int err_n = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        cmp_n++;
        if (act != exp) begin
            err_n++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a queue of waiting products, mathematical sums
    // per accumulator width (index 0 = 16 bits, index 1 = 11 bits).
    bit     m_hold = 1'b0;
    int     m_cnt  = 0;
    bit     m_ovr  = 1'b0;
    longint m_sum [2] = '{0, 0};
    bit     m_ovf [2] = '{1'b0, 1'b0};
    int     wd    [2] = '{16, 11};
    int     pend  [$];

    task automatic m_zero();
        m_hold = 1'b0;
        m_cnt  = 0;
        m_ovr  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_sum[i] = 0;
            m_ovf[i] = 1'b0;
        end
    endtask

    task automatic m_fold(input int x);
        for (int i = 0; i < 2; i++) begin
            longint mx, mn, s;
            mx = (longint'(1) << (wd[i] - 1)) - 1;
            mn = -mx - 1;
            s  = m_sum[i] + x;
            if (s > mx || s < mn) begin
                m_ovf[i] = 1'b1;
                if (SAT)         s = (x < 0) ? mn : mx;
                else if (s > mx) s = s - (longint'(1) << wd[i]);
                else             s = s + (longint'(1) << wd[i]);
            end
            m_sum[i] = s;
        end
        m_cnt++;
        if (m_cnt == BURST) m_hold = 1'b1;
    endtask

    task automatic m_step();
        if (clear) begin
            m_zero();
            pend.delete();
        end else begin
            if (m_hold && acc_ready) m_zero();
            if (prod_valid) pend.push_back(int'(prod_in));
            if (!m_hold && pend.size() != 0) m_fold(pend.pop_front());
            if (pend.size() > DEPTH) begin
                void'(pend.pop_back());
                m_ovr = 1'b1;
            end
        end
    endtask

    initial forever begin
        @(posedge clock or posedge rst);
        if (rst) begin
            m_zero();
            pend.delete();
        end else begin
            m_step();
        end
    end

    initial forever begin
        @(negedge clock);
        chk("acc16",   acc16, m_sum[0]);
        chk("ovf16",   o16,   longint'(m_ovf[0]));
        chk("acc11",   acc11, m_sum[1]);
        chk("ovf11",   o11,   longint'(m_ovf[1]));
        chk("valid16", v16,   longint'(m_hold));
        chk("valid11", v11,   longint'(m_hold));
        chk("count16", c16,   m_cnt);
        chk("count11", c11,   m_cnt);
        chk("ovr16",   r16,   longint'(m_ovr));
        chk("ovr11",   r11,   longint'(m_ovr));
    end

    task automatic cyc(input bit v, input int p, input bit rdy, input bit clr);
        @(negedge clock);
        prod_valid = v;
        prod_in    = 10'(p);
        acc_ready  = rdy;
        clear      = clr;
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_acc", acc16, 0);
        chk("rst_valid", v16, 0);
        chk("rst_count", c16, 0);
        chk("rst_ovf", o16, 0);
        chk("rst_ovr", r16, 0);
        rst = 1'b0;

        // Basic burst: 24 - 15 + 100 - 9 = 100
        cyc(1, 24, 1, 0); cyc(1, -15, 1, 0); cyc(1, 100, 1, 0); cyc(1, -9, 1, 0);
        cyc(0, 0, 1, 0);
        chk("t1_sum", acc16, 100);
        chk("t1_valid", v16, 1);
        chk("t1_ovf", o16, 0);
        cyc(0, 0, 1, 0);
        chk("t1_valid_one_cycle", v16, 0);

        // Backpressure with two pending products
        cyc(1, 10, 0, 0); cyc(1, 20, 0, 0); cyc(1, 30, 0, 0); cyc(1, 40, 0, 0);
        cyc(1, 5, 0, 0); cyc(1, 7, 0, 0); cyc(0, 0, 0, 0);
        chk("t2_hold_sum", acc16, 100);
        chk("t2_hold_valid", v16, 1);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("t2_pend_count", c16, 2);
        chk("t2_pend_sum", acc16, 12);
        chk("t2_overrun", r16, 0);
        cyc(1, 1, 0, 0); cyc(1, 2, 0, 0); cyc(0, 0, 1, 0);
        chk("t2_second_sum", acc16, 15);
        cyc(0, 0, 0, 0);

        // Overrun: third product during HOLD is dropped
        cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
        cyc(1, 50, 0, 0); cyc(1, 60, 0, 0); cyc(1, 70, 0, 0); cyc(0, 0, 0, 0);
        chk("t3_overrun_set", r16, 1);
        chk("t3_hold_sum", acc16, 4);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        chk("t3_overrun_clr", r16, 0);
        cyc(1, 3, 0, 0); cyc(1, 4, 0, 0); cyc(0, 0, 1, 0);
        chk("t3_sum_no_drop", acc16, 117);
        cyc(0, 0, 0, 0);

        // Overflow on the 11-bit instance
        cyc(1, 256, 0, 0); cyc(1, 256, 0, 0); cyc(1, 256, 0, 0); cyc(1, 256, 0, 0);
        cyc(0, 0, 0, 0);
        chk("t4_acc16", acc16, 1024);
        chk("t4_ovf16", o16, 0);
        chk("t4_acc11", acc11, SAT ? 1023 : -1024);
        chk("t4_ovf11", o11, 1);
        cyc(0, 0, 1, 0);
        chk("t4_ovf11_sticky", o11, 1);
        cyc(0, 0, 0, 0);
        chk("t4_ovf11_cleared", o11, 0);
        cyc(1, -300, 1, 0); cyc(1, -300, 1, 0); cyc(1, -300, 1, 0); cyc(1, -300, 1, 0);
        cyc(0, 0, 1, 0);
        chk("t4_neg_acc11", acc11, SAT ? -1024 : 848);
        cyc(0, 0, 1, 0);

        // Asynchronous reset mid-burst
        cyc(1, 7, 0, 0); cyc(1, 8, 0, 0);
        @(posedge clock);
        #2;
        chk("t5_pre_count", c16, 2);
        rst = 1'b1;
        prod_valid = 1'b0;
        #1;
        chk("t5_rst_count", c16, 0);
        chk("t5_rst_acc", acc16, 0);
        @(negedge clock);
        rst = 1'b0;
        cyc(1, 1, 1, 0); cyc(1, 2, 1, 0); cyc(1, 3, 1, 0); cyc(1, 4, 1, 0);
        cyc(0, 0, 1, 0);
        chk("t5_fresh_sum", acc16, 10);
        cyc(0, 0, 1, 0);

        // clear with a coincident product, then clear during HOLD with pending
        cyc(1, 5, 0, 0); cyc(1, 6, 0, 0); cyc(1, 99, 0, 1); cyc(0, 0, 0, 0);
        chk("t6_clear_count", c16, 0);
        chk("t6_clear_acc", acc16, 0);
        cyc(1, 2, 0, 0); cyc(1, 2, 0, 0); cyc(1, 2, 0, 0); cyc(1, 2, 0, 0);
        cyc(1, 9, 0, 0); cyc(1, 9, 0, 0); cyc(0, 0, 0, 1); cyc(0, 0, 0, 0);
        chk("t6_clear_valid", v16, 0);
        cyc(1, 1, 1, 0); cyc(1, 1, 1, 0); cyc(1, 1, 1, 0); cyc(1, 1, 1, 0);
        cyc(0, 0, 1, 0);
        chk("t6_flushed_sum", acc16, 4);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, elapsed %0t, limit 100000", $time);
        $fatal(1);
    end

endmodule
